// File: rtl/memory_access_scheduler_if.sv
// Bus bundle between requesters, the scheduler and the shared memory_module.
// slave = scheduler view, master = environment view.
interface memory_access_scheduler_if #(
  parameter int NUM_REQ     = 4,
  parameter int MEMORY_SIZE = 10,
  parameter int HIDDEN_SIZE = 10,
  parameter int DATA_WIDTH  = 32
);
  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]                                  req_valid;
  logic [NUM_REQ-1:0]                                  req_ready;
  logic [NUM_REQ-1:0][HIDDEN_SIZE-1:0][DATA_WIDTH-1:0] req_z;

  logic                                   mem_start;
  logic [HIDDEN_SIZE-1:0][DATA_WIDTH-1:0] mem_z;
  logic                                   mem_done;
  logic [HIDDEN_SIZE-1:0][DATA_WIDTH-1:0] mem_z_hat;
  logic [MEMORY_SIZE-1:0][DATA_WIDTH-1:0] mem_q;

  logic                                   rsp_valid;
  logic                                   rsp_ready;
  logic [ID_W-1:0]                        rsp_id;
  logic [HIDDEN_SIZE-1:0][DATA_WIDTH-1:0] rsp_z_hat;
  logic [MEMORY_SIZE-1:0][DATA_WIDTH-1:0] rsp_q;
  logic                                   rsp_err;
  logic                                   busy;

  modport slave (
    input  req_valid, req_z, mem_done, mem_z_hat, mem_q, rsp_ready,
    output req_ready, mem_start, mem_z, rsp_valid, rsp_id, rsp_z_hat, rsp_q, rsp_err, busy
  );

  modport master (
    output req_valid, req_z, mem_done, mem_z_hat, mem_q, rsp_ready,
    input  req_ready, mem_start, mem_z, rsp_valid, rsp_id, rsp_z_hat, rsp_q, rsp_err, busy
  );
endinterface

// File: rtl/memory_access_scheduler.sv
// Round-robin arbiter sharing one memory_module between NUM_REQ requesters.
// Optional WAIT watchdog enabled by defining MEMSCHED_TIMEOUT_EN.
module memory_access_scheduler #(
  parameter int NUM_REQ        = 4,
  parameter int MEMORY_SIZE    = 10,
  parameter int HIDDEN_SIZE    = 10,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                       clk,
  input  logic                       reset,
  memory_access_scheduler_if.slave   bus
);
  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef logic [HIDDEN_SIZE-1:0][DATA_WIDTH-1:0] zvec_t;
  typedef logic [MEMORY_SIZE-1:0][DATA_WIDTH-1:0] qvec_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [ID_W-1:0]  ptr_q, ptr_d;
  logic [ID_W-1:0]  rsp_id_q, rsp_id_d;
  zvec_t            mem_z_q, mem_z_d;
  zvec_t            rsp_z_hat_q, rsp_z_hat_d;
  qvec_t            rsp_q_q, rsp_q_d;
  logic             mem_start_q, mem_start_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_err_q, rsp_err_d;
  logic             busy_q, busy_d;

  logic [ID_W-1:0]    grant_idx_s;
  logic               grant_found_s;
  logic [NUM_REQ-1:0] req_ready_s;

`ifdef MEMSCHED_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
`else
  logic unused_timeout_s;
  assign unused_timeout_s = (TIMEOUT_CYCLES > 0);
`endif

  // Round-robin pick: descending scan so the candidate closest to ptr wins.
  always_comb begin
    int unsigned idx;
    idx           = 0;
    grant_found_s = 1'b0;
    grant_idx_s   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = (int'(ptr_q) + k) % NUM_REQ;
      if (bus.req_valid[idx]) begin
        grant_found_s = 1'b1;
        grant_idx_s   = ID_W'(idx);
      end else begin
        grant_found_s = grant_found_s;
      end
    end
  end

  // Next-state and datapath capture for the scheduling FSM.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    rsp_id_d    = rsp_id_q;
    mem_z_d     = mem_z_q;
    rsp_z_hat_d = rsp_z_hat_q;
    rsp_q_d     = rsp_q_q;
    rsp_err_d   = rsp_err_q;
    rsp_valid_d = rsp_valid_q;
    mem_start_d = 1'b0;
    req_ready_s = '0;
`ifdef MEMSCHED_TIMEOUT_EN
    wait_cnt_d  = wait_cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (grant_found_s) begin
          req_ready_s = {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_idx_s;
          mem_z_d     = bus.req_z[grant_idx_s];
          rsp_id_d    = grant_idx_s;
          if (grant_idx_s == ID_W'(NUM_REQ - 1)) begin
            ptr_d = '0;
          end else begin
            ptr_d = grant_idx_s + ID_W'(1);
          end
          mem_start_d = 1'b1;
          state_d     = ST_START;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: begin
        state_d = ST_WAIT;
`ifdef MEMSCHED_TIMEOUT_EN
        wait_cnt_d = '0;
`endif
      end
      ST_WAIT: begin
        // A done coinciding with the watchdog limit still counts as a normal completion.
        if (bus.mem_done) begin
          rsp_z_hat_d = bus.mem_z_hat;
          rsp_q_d     = bus.mem_q;
          rsp_err_d   = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = ST_RESP;
        end else begin
`ifdef MEMSCHED_TIMEOUT_EN
          if (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            rsp_z_hat_d = '0;
            rsp_q_d     = '0;
            rsp_err_d   = 1'b1;
            rsp_valid_d = 1'b1;
            state_d     = ST_RESP;
          end else begin
            wait_cnt_d = wait_cnt_q + CNT_W'(1);
          end
`else
          state_d = ST_WAIT;
`endif
        end
      end
      ST_RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers; reset aborts any job in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      rsp_id_q    <= '0;
      mem_z_q     <= '0;
      rsp_z_hat_q <= '0;
      rsp_q_q     <= '0;
      rsp_err_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      mem_start_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef MEMSCHED_TIMEOUT_EN
      wait_cnt_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      rsp_id_q    <= rsp_id_d;
      mem_z_q     <= mem_z_d;
      rsp_z_hat_q <= rsp_z_hat_d;
      rsp_q_q     <= rsp_q_d;
      rsp_err_q   <= rsp_err_d;
      rsp_valid_q <= rsp_valid_d;
      mem_start_q <= mem_start_d;
      busy_q      <= busy_d;
`ifdef MEMSCHED_TIMEOUT_EN
      wait_cnt_q  <= wait_cnt_d;
`endif
    end
  end

  assign bus.req_ready = req_ready_s & {NUM_REQ{reset}};
  assign bus.mem_start = mem_start_q;
  assign bus.mem_z     = mem_z_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_z_hat = rsp_z_hat_q;
  assign bus.rsp_q     = rsp_q_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.busy      = busy_q;
endmodule

// File: tb/tb_memory_access_scheduler.sv
// Self-checking bench: transaction-level reference model, memory_module stand-in,
// directed scenarios followed by randomized traffic with occasional resets.
module tb_memory_access_scheduler;
  localparam int N  = 4;
  localparam int MS = 10;
  localparam int HS = 10;
  localparam int DW = 32;
  localparam int TO = 16;

  localparam int PH_IDLE  = 0;
  localparam int PH_START = 1;
  localparam int PH_WAIT  = 2;
  localparam int PH_RESP  = 3;

  typedef logic [HS-1:0][DW-1:0] zvec_t;
  typedef logic [MS-1:0][DW-1:0] qvec_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  memory_access_scheduler_if #(.NUM_REQ(N), .MEMORY_SIZE(MS), .HIDDEN_SIZE(HS), .DATA_WIDTH(DW)) bus ();

  memory_access_scheduler #(
    .NUM_REQ(N), .MEMORY_SIZE(MS), .HIDDEN_SIZE(HS), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int rr_pick(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) begin
      if (v[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  // Reference model: one job at a time, advanced once per cycle from sampled inputs.
  int    ph = PH_IDLE;
  int    m_ptr = 0;
  int    m_id = 0;
  int    m_wait = 0;
  logic  m_err = 1'b0;
  zvec_t m_z, m_zh;
  qvec_t m_q;
  int    rsp_ids[$];

  initial begin
    int g;
    logic [N-1:0] er;
    forever begin
      @(negedge clk);
      if (!reset) begin
        check("reset_ctrl", {bus.busy, bus.mem_start, bus.rsp_valid, bus.rsp_err, bus.req_ready}, '0);
        check("reset_data", {bus.mem_z, bus.rsp_id}, '0);
        ph    = PH_IDLE;
        m_ptr = 0;
      end else begin
        g  = rr_pick(bus.req_valid, m_ptr);
        er = '0;
        if (ph == PH_IDLE && g >= 0) er[g] = 1'b1;
        check("req_ready", bus.req_ready, er);
        check("ctrl", {bus.busy, bus.mem_start, bus.rsp_valid},
              {ph != PH_IDLE, ph == PH_START, ph == PH_RESP});
        if (ph != PH_IDLE) check("mem_z", bus.mem_z, m_z);
        if (ph == PH_RESP) begin
          check("rsp_id", bus.rsp_id, m_id);
          check("rsp_z_hat", bus.rsp_z_hat, m_zh);
          check("rsp_q", bus.rsp_q, m_q);
          check("rsp_err", bus.rsp_err, m_err);
        end
        case (ph)
          PH_IDLE: begin
            if (g >= 0) begin
              m_z   = bus.req_z[g];
              m_id  = g;
              m_ptr = (g + 1) % N;
              ph    = PH_START;
            end
          end
          PH_START: begin
            m_wait = 0;
            ph     = PH_WAIT;
          end
          PH_WAIT: begin
            m_wait++;
            if (bus.mem_done) begin
              m_zh  = bus.mem_z_hat;
              m_q   = bus.mem_q;
              m_err = 1'b0;
              ph    = PH_RESP;
            end
`ifdef MEMSCHED_TIMEOUT_EN
            else if (m_wait == TO) begin
              m_zh  = '0;
              m_q   = '0;
              m_err = 1'b1;
              ph    = PH_RESP;
            end
`endif
          end
          PH_RESP: begin
            if (bus.rsp_ready) begin
              rsp_ids.push_back(m_id);
              ph = PH_IDLE;
            end
          end
          default: ph = PH_IDLE;
        endcase
      end
    end
  end

  // memory_module stand-in: done after a latency (0 = never), noise on data otherwise.
  int mem_lat    = 3;
  bit rand_lat   = 1'b0;
  bit fixed_data = 1'b0;
  bit stale_arm  = 1'b0;

  initial begin
    int cd;
    logic acc_seen, done;
    zvec_t zh;
    qvec_t qq;
    cd = 0;
    bus.mem_done  = 1'b0;
    bus.mem_z_hat = '0;
    bus.mem_q     = '0;
    forever begin
      @(negedge clk);
      acc_seen = |bus.req_ready;
      if (!reset) cd = 0;
      else if (bus.mem_start) cd = rand_lat ? int'($urandom_range(1, 20)) : mem_lat;
      @(posedge clk);
      #1;
      done = 1'b0;
      if (cd > 0) begin
        cd--;
        if (cd == 0) done = 1'b1;
      end
      if (stale_arm && acc_seen) done = 1'b1;
      for (int k = 0; k < HS; k++) zh[k] = $urandom;
      for (int k = 0; k < MS; k++) qq[k] = $urandom;
      if (done && fixed_data) begin
        zh = {HS{32'h00800000}};
        qq = {MS{32'h0019999A}};
      end
      bus.mem_done  = done;
      bus.mem_z_hat = zh;
      bus.mem_q     = qq;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_req_z();
    for (int i = 0; i < N; i++)
      for (int k = 0; k < HS; k++) bus.req_z[i][k] = $urandom;
  endtask

  task automatic wait_rsp(input string name);
    int n;
    logic expired;
    n = 0;
    while (!bus.rsp_valid && n < 200) begin
      tick();
      n++;
    end
    expired = !bus.rsp_valid;
    check(name, expired, 1'b0);
  endtask

  // One job with rsp_ready low; records first mem_start / rsp_valid offsets from the request cycle.
  task automatic run_fixed(input logic [N-1:0] v, output int fs, output int fr, output int np);
    fs = -1;
    fr = -1;
    np = 0;
    bus.rsp_ready = 1'b0;
    bus.req_valid = v;
    for (int n = 0; n < 24; n++) begin
      @(negedge clk);
      if (n == 0) check("fixed_grant_ready", bus.req_ready, v);
      if (bus.mem_start) begin
        np++;
        if (fs < 0) fs = n;
      end
      if (bus.rsp_valid && fr < 0) fr = n;
      @(posedge clk);
      #1;
      if (n == 0) bus.req_valid = '0;
    end
  endtask

  task automatic release_rsp();
    bus.rsp_ready = 1'b1;
    tick();
  endtask

  initial begin
    int fs, fr, np, n;
    int exp_rr[8];
    zvec_t one_z;
    exp_rr = '{0, 1, 2, 3, 0, 1, 2, 3};
    reset = 1'b0;
    bus.req_valid = '0;
    bus.req_z     = '0;
    bus.rsp_ready = 1'b0;
    @(negedge clk);
    check("rst_ctrl_literal", {bus.busy, bus.mem_start, bus.rsp_valid, bus.rsp_err}, 4'b0000);
    check("rst_rsp_literal", {bus.rsp_z_hat, bus.rsp_q}, '0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    // Round-robin with all requesters valid.
    rand_lat = 1'b1;
    bus.rsp_ready = 1'b1;
    bus.req_valid = 4'hF;
    rsp_ids.delete();
    n = 0;
    while (rsp_ids.size() < 8 && n < 2000) begin
      rand_req_z();
      tick();
      n++;
    end
    bus.req_valid = '0;
    check("rr_count", rsp_ids.size(), 8);
    for (int i = 0; i < 8; i++) begin
      if (i < rsp_ids.size()) check("rr_order", rsp_ids[i], exp_rr[i]);
    end
    tick();

    // Single job with known data and latency 5.
    rand_lat = 1'b0;
    fixed_data = 1'b1;
    mem_lat = 5;
    one_z = {HS{32'h01000000}};
    bus.req_z[0] = one_z;
    run_fixed(4'b0001, fs, fr, np);
    check("single_start_offset", fs, 1);
    check("single_start_pulses", np, 1);
    check("single_rsp_offset", fr, 7);
    check("single_rsp_id", bus.rsp_id, 0);
    check("single_z_hat", bus.rsp_z_hat, {HS{32'h00800000}});
    check("single_q", bus.rsp_q, {MS{32'h0019999A}});
    check("single_mem_z", bus.mem_z, {HS{32'h01000000}});
    release_rsp();
    fixed_data = 1'b0;

    // Backpressure: response held for 10 cycles while others request.
    bus.rsp_ready = 1'b0;
    rand_req_z();
    bus.req_valid = 4'b0100;
    tick();
    bus.req_valid = '0;
    wait_rsp("bp_wait");
    bus.req_valid = 4'hF;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_no_ready", {bus.req_ready, bus.rsp_valid}, 5'b00001);
      check("bp_id", bus.rsp_id, 2);
      tick();
    end
    bus.req_valid = '0;
    release_rsp();
    @(negedge clk);
    check("bp_done", {bus.busy, bus.rsp_valid}, 2'b00);
    tick();

    // Stale done during START.
    stale_arm = 1'b1;
    mem_lat = 4;
    rand_req_z();
    bus.req_valid = 4'b1000;
    tick();
    bus.req_valid = '0;
    wait_rsp("stale_wait");
    stale_arm = 1'b0;
    check("stale_id", bus.rsp_id, 3);
    tick();
    tick();

    // Reset in WAIT, then requester 0 wins first.
    mem_lat = 30;
    bus.req_valid = 4'b0010;
    tick();
    bus.req_valid = '0;
    repeat (3) tick();
    check("pre_reset_busy", bus.busy, 1'b1);
    #2 reset = 1'b0;
    #1;
    check("mid_reset_ctrl", {bus.mem_start, bus.rsp_valid, bus.busy}, 3'b000);
    bus.req_valid = 4'hF;
    #1;
    check("mid_reset_ready", bus.req_ready, 4'b0000);
    @(posedge clk);
    #1 reset = 1'b1;
    mem_lat = 3;
    @(negedge clk);
    check("post_reset_grant", bus.req_ready, 4'b0001);
    tick();
    bus.req_valid = '0;
    bus.rsp_ready = 1'b1;
    wait_rsp("post_reset_wait");
    check("post_reset_id", bus.rsp_id, 0);
    tick();

    // Done in the 16th WAIT cycle.
    mem_lat = 16;
    run_fixed(4'b0010, fs, fr, np);
    check("late_done_rsp_offset", fr, 18);
    check("late_done_err", bus.rsp_err, 1'b0);
    release_rsp();
`ifdef MEMSCHED_TIMEOUT_EN
    mem_lat = 0;
    run_fixed(4'b0100, fs, fr, np);
    check("timeout_rsp_offset", fr, 18);
    check("timeout_err", bus.rsp_err, 1'b1);
    check("timeout_zero_data", {bus.rsp_z_hat, bus.rsp_q}, '0);
    release_rsp();
`endif

    // Randomized traffic with occasional reset pulses.
    rand_lat = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      bus.req_valid = N'($urandom);
      rand_req_z();
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
      reset = ($urandom_range(0, 499) != 0);
      tick();
    end
    reset = 1'b1;
    bus.req_valid = '0;
    bus.rsp_ready = 1'b1;
    repeat (60) tick();
    @(negedge clk);
    check("drain_idle", bus.busy, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
